if_window_addr_gen: RTL and testbench

IF_WINDOW_ADDR_GEN -- requirements
Module: if_window_addr_gen

---
 rtl/if_agen_pkg.sv | 16 +
 rtl/if_window_counter.sv | 69 ++++++
 rtl/if_window_addr_gen.sv | 129 ++++++++++++
 tb/tb_if_window_addr_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_agen_pkg.sv
// Shared types and default widths for the IF window address generator.
// The top and the offset/counter sub-module both import this package.
package if_agen_pkg;

  localparam int unsigned DEF_POINTER_SIZE         = 8;
  localparam int unsigned DEF_DEPTH                = 256;
  localparam int unsigned DEF_FILTER_SIZE_REG_SIZE = 8;
  localparam int unsigned DEF_STRIDE_SIZE          = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agen_state_e;

endpackage

// File: rtl/if_window_counter.sv
// Offset/counter pair for the sliding window plus the end-of-row compare.
// It is cleared on row start or abort and advanced by one accepted beat at a time.
module if_window_counter
  import if_agen_pkg::*;
#(
  parameter int unsigned FILTER_SIZE_REG_SIZE = DEF_FILTER_SIZE_REG_SIZE,
  parameter int unsigned STRIDE_SIZE          = DEF_STRIDE_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_advance,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] i_filter_size,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] i_row_len,
  input  logic [STRIDE_SIZE-1:0]          i_stride,
  output logic [FILTER_SIZE_REG_SIZE-1:0] o_offset,
  output logic [FILTER_SIZE_REG_SIZE-1:0] o_counter,
  output logic                            o_window_last,
  output logic                            o_row_end
);

  localparam int unsigned CW = FILTER_SIZE_REG_SIZE + 1;

  logic [FILTER_SIZE_REG_SIZE-1:0] r_offset;
  logic [FILTER_SIZE_REG_SIZE-1:0] r_counter;
  logic [FILTER_SIZE_REG_SIZE-1:0] w_offset_d;
  logic [FILTER_SIZE_REG_SIZE-1:0] w_counter_d;
  logic [CW-1:0]                   w_stride_ext;
  logic [CW-1:0]                   w_end_sum;

  assign w_stride_ext = CW'(i_stride);

  // One extra bit so filter_size == 0 can never alias onto counter == filter_size-1.
  assign o_window_last = (({1'b0, r_counter} + CW'(1)) == {1'b0, i_filter_size});

  // True when the window after the next stride would run past the row.
  assign w_end_sum = {1'b0, r_offset} + w_stride_ext + {1'b0, i_filter_size};
  assign o_row_end = (w_end_sum > {1'b0, i_row_len});

  always_comb begin
    w_offset_d  = r_offset;
    w_counter_d = r_counter;
    if (i_clear) begin
      w_offset_d  = '0;
      w_counter_d = '0;
    end else if (i_advance) begin
      if (o_window_last) begin
        w_counter_d = '0;
        w_offset_d  = r_offset + FILTER_SIZE_REG_SIZE'(i_stride);
      end else begin
        w_counter_d = r_counter + FILTER_SIZE_REG_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset  <= '0;
      r_counter <= '0;
    end else begin
      r_offset  <= w_offset_d;
      r_counter <= w_counter_d;
    end
  end

  assign o_offset  = r_offset;
  assign o_counter = r_counter;

endmodule

// File: rtl/if_window_addr_gen.sv
// Generates IF buffer read addresses for successive filter windows along one row,
// wrapping modulo DEPTH, with ready/valid backpressure, abort and a row_done pulse.
module if_window_addr_gen
  import if_agen_pkg::*;
#(
  parameter int unsigned POINTER_SIZE         = DEF_POINTER_SIZE,
  parameter int unsigned DEPTH                = DEF_DEPTH,
  parameter int unsigned FILTER_SIZE_REG_SIZE = DEF_FILTER_SIZE_REG_SIZE,
  parameter int unsigned STRIDE_SIZE          = DEF_STRIDE_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [STRIDE_SIZE-1:0]          i_stride,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] i_filter_size,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] i_row_len,
  input  logic [POINTER_SIZE-1:0]         i_base_ptr,
  input  logic                            i_addr_ready,
  output logic                            o_addr_valid,
  output logic [POINTER_SIZE-1:0]         o_read_pointer,
  output logic                            o_window_last,
  output logic                            o_row_done,
  output logic                            o_busy
);

  localparam int unsigned PW = POINTER_SIZE + 1;

  agen_state_e r_state;
  agen_state_e w_state_d;

  logic [STRIDE_SIZE-1:0]          r_stride;
  logic [FILTER_SIZE_REG_SIZE-1:0] r_filter_size;
  logic [FILTER_SIZE_REG_SIZE-1:0] r_row_len;
  logic [POINTER_SIZE-1:0]         r_base;

  logic                            w_accept;
  logic                            w_handshake;
  logic                            w_clear;
  logic                            w_empty_row;
  logic [STRIDE_SIZE-1:0]          w_stride_eff;
  logic [FILTER_SIZE_REG_SIZE-1:0] w_offset;
  logic [FILTER_SIZE_REG_SIZE-1:0] w_counter;
  logic                            w_cnt_last;
  logic                            w_row_end;
  logic [PW-1:0]                   w_sum;
  logic [POINTER_SIZE-1:0]         w_pointer;

  // abort outranks both start and a handshake in the same cycle.
  assign w_accept    = (r_state == IDLE) && i_start && !i_abort;
  assign w_handshake = (r_state == RUN) && i_addr_ready && !i_abort;
  assign w_clear     = w_accept || i_abort;
  assign w_empty_row = (i_filter_size == '0) || (i_filter_size > i_row_len);
  assign w_stride_eff = (r_stride == '0) ? STRIDE_SIZE'(1) : r_stride;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = w_empty_row ? DONE : RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_d = IDLE;
        end else if (w_handshake && w_cnt_last && w_row_end) begin
          w_state_d = DONE;
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride      <= '0;
      r_filter_size <= '0;
      r_row_len     <= '0;
      r_base        <= '0;
    end else if (w_accept) begin
      r_stride      <= i_stride;
      r_filter_size <= i_filter_size;
      r_row_len     <= i_row_len;
      r_base        <= i_base_ptr;
    end
  end

  if_window_counter #(
    .FILTER_SIZE_REG_SIZE(FILTER_SIZE_REG_SIZE),
    .STRIDE_SIZE         (STRIDE_SIZE)
  ) u_window_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_advance    (w_handshake),
    .i_filter_size(r_filter_size),
    .i_row_len    (r_row_len),
    .i_stride     (w_stride_eff),
    .o_offset     (w_offset),
    .o_counter    (w_counter),
    .o_window_last(w_cnt_last),
    .o_row_end    (w_row_end)
  );

  // Single conditional subtract: base < DEPTH and offset+counter < row_len keep sum < 2*DEPTH.
  assign w_sum     = PW'(r_base) + PW'(w_offset) + PW'(w_counter);
  assign w_pointer = POINTER_SIZE'((w_sum >= PW'(DEPTH)) ? (w_sum - PW'(DEPTH)) : w_sum);

  assign o_addr_valid   = (r_state == RUN);
  assign o_read_pointer = (r_state == RUN) ? w_pointer : '0;
  assign o_window_last  = (r_state == RUN) && w_cnt_last;
  assign o_row_done     = (r_state == DONE);
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_if_window_addr_gen.sv
// Randomised and directed bench for if_window_addr_gen; expected beats come from
// enumerating window offsets arithmetically, independent of the RTL structure.
module tb_if_window_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [2:0] i_stride = '0;
  logic [7:0] i_filter_size = '0;
  logic [7:0] i_row_len = '0;
  logic [7:0] i_base_ptr = '0;
  logic       i_addr_ready = 1'b0;
  logic       o_addr_valid;
  logic [7:0] o_read_pointer;
  logic       o_window_last;
  logic       o_row_done;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  int obs_ptr[$];
  int obs_last[$];
  int exp_ptr[$];
  int exp_last[$];
  int done_pulses, done_cyc, first_valid_cyc, last_beat_cyc, stall_bad, timed_out;

  always #5 clk = ~clk;

  if_window_addr_gen dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_stride      (i_stride),
    .i_filter_size (i_filter_size),
    .i_row_len     (i_row_len),
    .i_base_ptr    (i_base_ptr),
    .i_addr_ready  (i_addr_ready),
    .o_addr_valid  (o_addr_valid),
    .o_read_pointer(o_read_pointer),
    .o_window_last (o_window_last),
    .o_row_done    (o_row_done),
    .o_busy        (o_busy)
  );

  // Every window starts at a multiple of the stride and must fit inside the row.
  task automatic model_row(input int base, input int fs, input int stride, input int row);
    int s;
    s = (stride == 0) ? 1 : stride;
    exp_ptr.delete();
    exp_last.delete();
    if (fs == 0 || fs > row) return;
    for (int off = 0; off + fs <= row; off += s) begin
      for (int c = 0; c < fs; c++) begin
        exp_ptr.push_back((base + off + c) % 256);
        exp_last.push_back((c == fs - 1) ? 1 : 0);
      end
    end
  endtask

  function automatic int first_diff();
    if (obs_ptr.size() != exp_ptr.size()) return -2;
    foreach (exp_ptr[k]) begin
      if (obs_ptr[k] != exp_ptr[k] || obs_last[k] != exp_last[k]) return k;
    end
    return -1;
  endfunction

  // Starts a row and records accepted beats; ready_pct < 0 means ready toggles 1,0,1,0.
  task automatic run_row(input int base, input int fs, input int stride, input int row,
                         input int ready_pct, input int mid_start_cyc);
    logic       prev_stall, rdy, tog;
    logic [7:0] prev_ptr;
    logic       prev_last;
    obs_ptr.delete();
    obs_last.delete();
    done_pulses = 0; done_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
    stall_bad = 0; timed_out = 1; prev_stall = 1'b0; tog = 1'b1;
    prev_ptr = '0; prev_last = 1'b0;
    @(negedge clk);
    i_base_ptr = 8'(base); i_filter_size = 8'(fs); i_row_len = 8'(row);
    i_stride = 3'(stride); i_start = 1'b1; i_addr_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if (prev_stall && (o_addr_valid !== 1'b1 || o_read_pointer !== prev_ptr ||
                         o_window_last !== prev_last)) stall_bad++;
      prev_stall = 1'b0;
      if (o_row_done === 1'b1) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (o_busy === 1'b0) begin
        timed_out = 0;
        break;
      end
      if (o_addr_valid === 1'b1) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (ready_pct < 0) begin
          rdy = tog; tog = ~tog;
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
        end
        i_addr_ready = rdy;
        if (rdy) begin
          obs_ptr.push_back(int'(o_read_pointer));
          obs_last.push_back(int'(o_window_last));
          last_beat_cyc = cyc;
        end else begin
          prev_stall = 1'b1; prev_ptr = o_read_pointer; prev_last = o_window_last;
        end
      end else begin
        i_addr_ready = 1'($urandom_range(1));
      end
      if (cyc == mid_start_cyc) begin
        i_start = 1'b1; i_base_ptr = 8'd100; i_filter_size = 8'd2;
        i_row_len = 8'd9; i_stride = 3'd3;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    i_addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({o_addr_valid, o_read_pointer, o_window_last, o_row_done, o_busy} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b p=%0d l=%b d=%b b=%b want all 0",
               o_addr_valid, o_read_pointer, o_window_last, o_row_done, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_addr_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle: got busy=%b valid=%b want 0 0", o_busy, o_addr_valid);
    end
  endtask

  task automatic test_case1();
    int d;
    run_row(0, 3, 1, 5, 100, -1);
    model_row(0, 3, 1, 5);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1) begin
      bad++;
      $display("FAIL case1_seq: got diff_at=%0d n=%0d timeout=%0d want -1 n=%0d",
               d, obs_ptr.size(), timed_out, exp_ptr.size());
    end
    total++;
    if (first_valid_cyc != 1) begin
      bad++;
      $display("FAIL case1_first_latency: got %0d want 1", first_valid_cyc);
    end
    total++;
    if (last_beat_cyc != 9) begin
      bad++;
      $display("FAIL case1_throughput: got last beat cycle %0d want 9", last_beat_cyc);
    end
    total++;
    if (done_cyc != last_beat_cyc + 1 || done_pulses != 1) begin
      bad++;
      $display("FAIL case1_row_done: got cyc=%0d pulses=%0d want cyc=%0d pulses=1",
               done_cyc, done_pulses, last_beat_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    int d;
    run_row(254, 2, 2, 6, 100, -1);
    model_row(254, 2, 2, 6);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1 || obs_ptr.size() != 6) begin
      bad++;
      $display("FAIL wrap_seq: got diff_at=%0d n=%0d want -1 n=6", d, obs_ptr.size());
    end
  endtask

  task automatic test_backpressure();
    int d;
    run_row(0, 3, 1, 5, -1, -1);
    model_row(0, 3, 1, 5);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1) begin
      bad++;
      $display("FAIL toggle_seq: got diff_at=%0d n=%0d want -1 n=%0d",
               d, obs_ptr.size(), exp_ptr.size());
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL toggle_hold: got %0d unstable stall cycles want 0", stall_bad);
    end
  endtask

  task automatic test_degenerate();
    run_row(0, 4, 1, 3, 100, -1);
    total++;
    if (obs_ptr.size() != 0 || first_valid_cyc != -1 || done_cyc != 1 || done_pulses != 1) begin
      bad++;
      $display("FAIL fs_gt_row: got beats=%0d valid_cyc=%0d done_cyc=%0d pulses=%0d want 0 -1 1 1",
               obs_ptr.size(), first_valid_cyc, done_cyc, done_pulses);
    end
    run_row(5, 0, 2, 7, 100, -1);
    total++;
    if (obs_ptr.size() != 0 || done_cyc != 1 || done_pulses != 1) begin
      bad++;
      $display("FAIL fs_zero: got beats=%0d done_cyc=%0d pulses=%0d want 0 1 1",
               obs_ptr.size(), done_cyc, done_pulses);
    end
  endtask

  task automatic test_abort();
    int beats, dones, d;
    beats = 0; dones = 0;
    @(negedge clk);
    i_base_ptr = 8'd0; i_filter_size = 8'd3; i_row_len = 8'd5; i_stride = 3'd1;
    i_start = 1'b1; i_addr_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
      if (o_addr_valid === 1'b1) beats++;
      if (beats == 4) i_abort = 1'b1;
      @(negedge clk);
    end
    i_abort = 1'b0;
    total++;
    if (o_addr_valid !== 1'b0 || o_busy !== 1'b0 || beats != 4) begin
      bad++;
      $display("FAIL abort_stop: got valid=%b busy=%b beats=%0d want 0 0 4",
               o_addr_valid, o_busy, beats);
    end
    for (int k = 0; k < 4; k++) begin
      if (o_row_done === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d row_done cycles want 0", dones);
    end
    run_row(0, 3, 1, 5, 100, -1);
    model_row(0, 3, 1, 5);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1 || done_pulses != 1) begin
      bad++;
      $display("FAIL abort_replay: got diff_at=%0d pulses=%0d want -1 1", d, done_pulses);
    end
  endtask

  task automatic test_midrow_reset();
    int dones;
    dones = 0;
    @(negedge clk);
    i_base_ptr = 8'd7; i_filter_size = 8'd3; i_row_len = 8'd9; i_stride = 3'd2;
    i_start = 1'b1; i_addr_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({o_addr_valid, o_read_pointer, o_window_last, o_row_done, o_busy} !== 12'd0) begin
      bad++;
      $display("FAIL midrow_reset_outputs: got v=%b p=%0d l=%b d=%b b=%b want all 0",
               o_addr_valid, o_read_pointer, o_window_last, o_row_done, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (o_row_done === 1'b1 || o_busy === 1'b1) dones++;
      @(negedge clk);
    end
    i_addr_ready = 1'b0;
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL midrow_reset_discard: got %0d busy/done cycles want 0", dones);
    end
  endtask

  task automatic test_start_busy();
    int d;
    run_row(0, 3, 1, 5, 100, 4);
    model_row(0, 3, 1, 5);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1) begin
      bad++;
      $display("FAIL start_in_run: got diff_at=%0d n=%0d want -1 n=%0d",
               d, obs_ptr.size(), exp_ptr.size());
    end
    run_row(0, 3, 1, 5, 100, 10);
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || done_pulses != 1) begin
      bad++;
      $display("FAIL start_in_done: got busy=%b pulses=%0d want 0 1", o_busy, done_pulses);
    end
  endtask

  task automatic test_stride_zero();
    int d;
    run_row(0, 3, 0, 5, 100, -1);
    model_row(0, 3, 1, 5);
    d = first_diff();
    total++;
    if (timed_out != 0 || d != -1) begin
      bad++;
      $display("FAIL stride_zero: got diff_at=%0d n=%0d want -1 n=%0d",
               d, obs_ptr.size(), exp_ptr.size());
    end
  endtask

  task automatic test_random();
    int base, fs, st, row, pct, d;
    for (int it = 0; it < 30; it++) begin
      base = $urandom_range(255);
      fs   = $urandom_range(12);
      row  = $urandom_range(24);
      st   = $urandom_range(7);
      pct  = $urandom_range(100, 30);
      run_row(base, fs, st, row, pct, -1);
      model_row(base, fs, st, row);
      d = first_diff();
      total++;
      if (timed_out != 0 || d != -1 || done_pulses != 1 || stall_bad != 0) begin
        bad++;
        $display("FAIL random_row%0d: got diff_at=%0d n=%0d pulses=%0d stall_bad=%0d to=%0d want -1 n=%0d 1 0 0 (b=%0d fs=%0d s=%0d row=%0d)",
                 it, d, obs_ptr.size(), done_pulses, stall_bad, timed_out, exp_ptr.size(),
                 base, fs, st, row);
      end
    end
  endtask

  initial begin
    test_reset();
    test_case1();
    test_wrap();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_midrow_reset();
    test_start_busy();
    test_stride_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
